// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types, constants and access checks for the data memory
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } responderState;

    localparam int WORD_BYTES = 4;

    // Shared with the instruction-memory side: misaligned or beyond the last word.
    function automatic logic access_error(input logic [31:0] address,
                                          input int unsigned depth_words);
        return (address[1:0] != 2'b00) || ({2'b00, address[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/memory_array.sv
// rtl/memory_array.sv - word storage with synchronous write and combinational read
module memory_array #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           i_clock,
    input  logic                           i_wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_wr_index,
    input  logic [31:0]                    i_wr_data,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_rd_index,
    output logic [31:0]                    o_rd_data
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_index];

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - valid/ready load/store responder with programmable wait states
module memory_responder
    import memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respReadData,
    output logic        respError
);

    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int OFFSET_W = $clog2(WORD_BYTES);
    localparam logic [3:0] COUNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    responderState r_state;
    responderState w_next_state;

    logic [3:0]       r_count;
    logic             r_write;
    logic [31:0]      r_address;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_error;

    logic             w_accept;
    logic             w_commit;
    logic             w_done;
    logic             w_acc_write;
    logic [31:0]      w_acc_address;
    logic [31:0]      w_acc_wdata;
    logic             w_acc_error;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_mem_rdata;

    assign w_accept = (r_state == IDLE) && reqValid;
    assign w_done   = (r_state == RESPOND) && respReady;

    // With zero wait states the access commits on the accept edge, before the latches hold it.
    assign w_acc_write   = (r_state == IDLE) ? reqWrite     : r_write;
    assign w_acc_address = (r_state == IDLE) ? reqAddress   : r_address;
    assign w_acc_wdata   = (r_state == IDLE) ? reqWriteData : r_wdata;
    assign w_acc_error   = access_error(w_acc_address, DEPTH_WORDS);
    assign w_index       = w_acc_address[IDX_W+OFFSET_W-1:OFFSET_W];

    assign w_commit = (w_next_state == RESPOND) && (r_state != RESPOND);
    assign w_mem_we = w_commit && w_acc_write && !w_acc_error;

    always_comb begin
        w_next_state = r_state;
        reqReady     = 1'b0;
        respValid    = 1'b0;
        case (r_state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    w_next_state = (WAIT_STATES > 0) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = RESPOND;
                end
            end
            RESPOND: begin
                respValid = 1'b1;
                if (respReady) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_count   <= 4'd0;
            r_write   <= 1'b0;
            r_address <= 32'd0;
            r_wdata   <= 32'd0;
        end else if (w_accept) begin
            r_count   <= COUNT_LOAD;
            r_write   <= reqWrite;
            r_address <= reqAddress;
            r_wdata   <= reqWriteData;
        end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else if (w_commit) begin
            r_error <= w_acc_error;
            r_rdata <= (w_acc_error || w_acc_write) ? 32'd0 : w_mem_rdata;
        end else if (w_done) begin
            r_error <= 1'b0;
            r_rdata <= 32'd0;
        end
    end

    assign respReadData = r_rdata;
    assign respError    = r_error;

    memory_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_memory_array (
        .i_clock    (clock),
        .i_wr_en    (w_mem_we),
        .i_wr_index (w_index),
        .i_wr_data  (w_acc_wdata),
        .i_rd_index (w_index),
        .o_rd_data  (w_mem_rdata)
    );

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - randomized self-checking bench for memory_responder
module tb_memory_responder;

    localparam int DEPTH = 256;

    logic        clock = 1'b0;
    logic        resetN       [2];
    logic        reqValid     [2];
    logic        reqReady     [2];
    logic        reqWrite     [2];
    logic [31:0] reqAddress   [2];
    logic [31:0] reqWriteData [2];
    logic        respValid    [2];
    logic        respReady    [2];
    logic [31:0] respReadData [2];
    logic        respError    [2];

    logic [31:0] model_mem   [2][DEPTH];
    bit          model_known [2][DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        memory_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_STATES((g == 0) ? 2 : 0)
        ) u_dut (
            .clock        (clock),
            .resetN       (resetN[g]),
            .reqValid     (reqValid[g]),
            .reqReady     (reqReady[g]),
            .reqWrite     (reqWrite[g]),
            .reqAddress   (reqAddress[g]),
            .reqWriteData (reqWriteData[g]),
            .respValid    (respValid[g]),
            .respReady    (respReady[g]),
            .respReadData (respReadData[g]),
            .respError    (respError[g])
        );
    end

    function automatic int ws_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected response from the rules: error on misalignment or word index past the end.
    task automatic expect_resp(input int u, input bit wr, input logic [31:0] addr,
                               output bit exp_err, output logic [31:0] exp_data, output bit chk_data);
        logic [31:0] word;
        word     = addr / 4;
        exp_err  = ((addr % 4) != 0) || (word >= DEPTH);
        chk_data = 1'b1;
        exp_data = 32'd0;
        if (!exp_err && !wr) begin
            chk_data = model_known[u][word];
            exp_data = model_mem[u][word];
        end
    endtask

    task automatic model_commit(input int u, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        if (wr && (addr % 4) == 0 && (addr / 4) < DEPTH) begin
            model_mem[u][addr / 4]   = data;
            model_known[u][addr / 4] = 1'b1;
        end
    endtask

    task automatic access(input int u, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int hold);
        bit          exp_err;
        bit          chk_data;
        logic [31:0] exp_data;
        int          k;
        expect_resp(u, wr, addr, exp_err, exp_data, chk_data);
        @(negedge clock);
        reqValid[u]     = 1'b1;
        reqWrite[u]     = wr;
        reqAddress[u]   = addr;
        reqWriteData[u] = data;
        check("accept_ready", reqReady[u], 1);
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                reqValid[u]     = 1'b0;
                reqWrite[u]     = 1'($urandom);
                reqAddress[u]   = $urandom;
                reqWriteData[u] = $urandom;
            end
        end while (!respValid[u] && k < 40);
        model_commit(u, wr, addr, data);
        check("latency", k, ws_of(u) + 1);
        check("resp_ready_busy", reqReady[u], 0);
        check("resp_error", respError[u], exp_err);
        if (chk_data) check("resp_data", respReadData[u], exp_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", respValid[u], 1);
            check("hold_req_ready", reqReady[u], 0);
            check("hold_error", respError[u], exp_err);
            if (chk_data) check("hold_data", respReadData[u], exp_data);
        end
        respReady[u] = 1'b1;
        @(negedge clock);
        respReady[u] = 1'b0;
        check("idle_ready", reqReady[u], 1);
        check("idle_valid", respValid[u], 0);
        check("idle_data", respReadData[u], 0);
        check("idle_error", respError[u], 0);
    endtask

    // Continuous traffic with reqValid held high: accepts must land every other cycle.
    task automatic burst(input int u);
        bit          wr   [4];
        logic [31:0] addr [4];
        logic [31:0] data [4];
        bit          exp_err;
        bit          chk_data;
        logic [31:0] exp_data;
        wr   = '{1'b1, 1'b1, 1'b0, 1'b0};
        addr = '{32'h0, 32'h4, 32'h0, 32'h4};
        data[0] = $urandom;
        data[1] = $urandom;
        data[2] = $urandom;
        data[3] = $urandom;
        @(negedge clock);
        respReady[u] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_resp(u, wr[i], addr[i], exp_err, exp_data, chk_data);
            reqValid[u]     = 1'b1;
            reqWrite[u]     = wr[i];
            reqAddress[u]   = addr[i];
            reqWriteData[u] = data[i];
            check("burst_accept_ready", reqReady[u], 1);
            @(negedge clock);
            model_commit(u, wr[i], addr[i], data[i]);
            check("burst_valid", respValid[u], 1);
            check("burst_error", respError[u], exp_err);
            if (chk_data) check("burst_data", respReadData[u], exp_data);
            @(negedge clock);
        end
        reqValid[u]  = 1'b0;
        respReady[u] = 1'b0;
        check("burst_end_ready", reqReady[u], 1);
        check("burst_end_valid", respValid[u], 0);
    endtask

    task automatic reset_mid_wait(input int u);
        logic [31:0] prior;
        prior = $urandom;
        access(u, 1'b1, 32'h20, prior, 0);
        @(negedge clock);
        reqValid[u]     = 1'b1;
        reqWrite[u]     = 1'b1;
        reqAddress[u]   = 32'h20;
        reqWriteData[u] = 32'hCAFEF00D;
        @(negedge clock);
        reqValid[u] = 1'b0;
        #2 resetN[u] = 1'b0;
        #1;
        check("rst_req_ready", reqReady[u], 1);
        check("rst_resp_valid", respValid[u], 0);
        check("rst_resp_data", respReadData[u], 0);
        check("rst_resp_error", respError[u], 0);
        @(negedge clock);
        resetN[u] = 1'b1;
        access(u, 1'b0, 32'h20, 32'd0, 0);
    endtask

    task automatic random_traffic(input int u, input int n);
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
            else if (r == 1) addr = 32'h400 + 4 * $urandom_range(0, 4000);
            else if (r == 2) addr = 32'h3FC;
            else             addr = $urandom_range(0, 15) * 4;
            access(u, 1'($urandom), addr, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            resetN[u]       = 1'b0;
            reqValid[u]     = 1'b0;
            reqWrite[u]     = 1'b0;
            reqAddress[u]   = 32'd0;
            reqWriteData[u] = 32'd0;
            respReady[u]    = 1'b0;
            for (int w = 0; w < DEPTH; w++) model_known[u][w] = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            check("reset_req_ready", reqReady[u], 1);
            check("reset_resp_valid", respValid[u], 0);
            check("reset_resp_data", respReadData[u], 0);
            check("reset_resp_error", respError[u], 0);
            resetN[u] = 1'b1;
        end

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        access(0, 1'b0, 32'h10, 32'd0, 0);
        access(0, 1'b1, 32'h13, 32'h12345678, 0);
        access(0, 1'b0, 32'h10, 32'd0, 0);
        access(0, 1'b1, 32'h0, $urandom, 0);
        access(0, 1'b0, 32'h400, 32'd0, 0);
        access(0, 1'b1, 32'h400, $urandom, 1);
        access(0, 1'b0, 32'h0, 32'd0, 0);
        access(0, 1'b0, 32'h10, 32'd0, 5);
        reset_mid_wait(0);

        burst(1);
        access(1, 1'b0, 32'h4, 32'd0, 5);

        random_traffic(0, 40);
        random_traffic(1, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
